// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer
//   Queues per-instruction retire records from a single-cycle core in a
//   circular FIFO and streams them out over valid/ready. The core is never
//   stalled: a record that arrives while the FIFO is full and not draining
//   is dropped, counted and flagged.
// Ports
//   clk_i, rst_i (async, active-high)
//   update_i + pc_i/instr_i/reg_addr_i/reg_data_i/mem_addr_i/mem_data_i/mem_wrt_i : retire record in
//   trace_valid_o/trace_ready_i + trace_* fields : head record stream out
//   fill_o        : occupancy 0..DEPTH
//   retired_cnt_o : retire pulses seen (wrapping)
//   dropped_cnt_o : records lost to a full FIFO (saturating)
//   overflow_o    : sticky drop indicator
//   clear_i       : synchronous clear of counters and overflow flag
module retire_trace_buffer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     update_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [XLEN-1:0]          instr_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  input  logic [XLEN-1:0]          mem_addr_i,
  input  logic [XLEN-1:0]          mem_data_i,
  input  logic                     mem_wrt_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [XLEN-1:0]          trace_pc_o,
  output logic [XLEN-1:0]          trace_instr_o,
  output logic [4:0]               trace_reg_addr_o,
  output logic [XLEN-1:0]          trace_reg_data_o,
  output logic [XLEN-1:0]          trace_mem_addr_o,
  output logic [XLEN-1:0]          trace_mem_data_o,
  output logic                     trace_mem_wrt_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic [31:0]              retired_cnt_o,
  output logic [31:0]              dropped_cnt_o,
  output logic                     overflow_o,
  input  logic                     clear_i
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] reg_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            mem_wrt;
  } rec_t;

  rec_t            mem [DEPTH];
  rec_t            wr_rec;
  rec_t            head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     fill;
  logic            pop;
  logic            push;
  logic            drop;
  logic            full;

  always_comb begin
    full = (fill == FULL);
    pop  = (fill != '0) && trace_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push = update_i && (!full || pop);
    drop = update_i && full && !pop;

    wr_rec          = '0;
    wr_rec.pc       = pc_i;
    wr_rec.instr    = instr_i;
    wr_rec.reg_addr = reg_addr_i;
    wr_rec.reg_data = reg_data_i;
    wr_rec.mem_addr = mem_addr_i;
    wr_rec.mem_data = mem_data_i;
    wr_rec.mem_wrt  = mem_wrt_i;
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wr_rec;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fill <= fill + (AW+1)'(1);
      else if (pop && !push) fill <= fill - (AW+1)'(1);
    end
  end

  // clear_i overrides the normal update but still counts this cycle's events.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      retired_cnt_o <= '0;
      dropped_cnt_o <= '0;
      overflow_o    <= 1'b0;
    end else if (clear_i) begin
      retired_cnt_o <= update_i ? 32'd1 : 32'd0;
      dropped_cnt_o <= drop ? 32'd1 : 32'd0;
      overflow_o    <= drop;
    end else begin
      if (update_i) retired_cnt_o <= retired_cnt_o + 32'd1;
      if (drop && (dropped_cnt_o != '1)) dropped_cnt_o <= dropped_cnt_o + 32'd1;
      if (drop) overflow_o <= 1'b1;
    end
  end

  always_comb begin
    head             = mem[rd_ptr];
    trace_valid_o    = (fill != '0);
    trace_pc_o       = head.pc;
    trace_instr_o    = head.instr;
    trace_reg_addr_o = head.reg_addr;
    trace_reg_data_o = head.reg_data;
    trace_mem_addr_o = head.mem_addr;
    trace_mem_data_o = head.mem_data;
    trace_mem_wrt_o  = head.mem_wrt;
    fill_o           = fill;
  end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb_retire_trace_buffer
//   Directed bench for retire_trace_buffer (XLEN=32, DEPTH=8): reset,
//   ordering, overflow, full push+pop, clear, counter wrap/saturation and a
//   pseudo-random backpressure run against a queue model.
module tb_retire_trace_buffer;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned FW    = 5*XLEN + 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            update;
  logic [XLEN-1:0] pc, instr, reg_data, mem_addr, mem_data;
  logic [4:0]      reg_addr;
  logic            mem_wrt;
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] t_pc, t_instr, t_reg_data, t_mem_addr, t_mem_data;
  logic [4:0]      t_reg_addr;
  logic            t_mem_wrt;
  logic [3:0]      fill;
  logic [31:0]     retired, dropped;
  logic            overflow;
  logic            clear;

  int total = 0;
  int bad   = 0;

  retire_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .update_i(update),
    .pc_i(pc), .instr_i(instr), .reg_addr_i(reg_addr), .reg_data_i(reg_data),
    .mem_addr_i(mem_addr), .mem_data_i(mem_data), .mem_wrt_i(mem_wrt),
    .trace_valid_o(valid), .trace_ready_i(ready),
    .trace_pc_o(t_pc), .trace_instr_o(t_instr), .trace_reg_addr_o(t_reg_addr),
    .trace_reg_data_o(t_reg_data), .trace_mem_addr_o(t_mem_addr),
    .trace_mem_data_o(t_mem_data), .trace_mem_wrt_o(t_mem_wrt),
    .fill_o(fill), .retired_cnt_o(retired), .dropped_cnt_o(dropped),
    .overflow_o(overflow), .clear_i(clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every record field is derived from the PC so the whole record is checkable.
  function automatic logic [FW-1:0] exp_fields(input logic [31:0] p);
    logic [31:0] a;
    a = p;
    return {p, ~p, a[6:2], p + 32'd1, p + 32'd2, p + 32'd3, a[2]};
  endfunction

  function automatic logic [FW-1:0] obs_fields();
    return {t_pc, t_instr, t_reg_addr, t_reg_data, t_mem_addr, t_mem_data, t_mem_wrt};
  endfunction

  task automatic set_rec(input logic [31:0] p);
    pc       = p;
    instr    = ~p;
    reg_addr = p[6:2];
    reg_data = p + 32'd1;
    mem_addr = p + 32'd2;
    mem_data = p + 32'd3;
    mem_wrt  = p[2];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] q[$];
    logic [FW-1:0] prev;
    logic stall, rdy, upd, pop;
    int sent, cyc;

    rst = 1'b1; update = 1'b0; ready = 1'b0; clear = 1'b0;
    set_rec(32'h0);
    #12;
    check("rst_fill", fill, 0);
    check("rst_valid", valid, 0);
    check("rst_retired", retired, 0);
    check("rst_dropped", dropped, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    #1;

    // Three pushes, no pop
    for (int i = 0; i < 3; i++) begin
      set_rec(32'(4*i)); update = 1'b1; tick();
    end
    update = 1'b0;
    check("p3_fill", fill, 3);
    check("p3_valid", valid, 1);
    check("p3_pc", t_pc, 32'h0);
    check("p3_fields", obs_fields(), exp_fields(32'h0));
    check("p3_retired", retired, 3);

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    check("arst_fill", fill, 0);
    check("arst_valid", valid, 0);
    check("arst_retired", retired, 0);
    #1 rst = 1'b0;

    // Ordering with consumer always ready: one-cycle latency, fill <= 1
    ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rec(32'(4*i)); update = 1'b1; tick();
      check($sformatf("ord_fields%0d", i), obs_fields(), exp_fields(32'(4*i)));
      check($sformatf("ord_fill%0d", i), fill, 1);
    end
    update = 1'b0; tick();
    check("ord_empty_fill", fill, 0);
    check("ord_empty_valid", valid, 0);
    check("ord_dropped", dropped, 0);
    check("ord_retired", retired, 8);

    // Overflow: 10 pushes, consumer stalled
    ready = 1'b0; clear = 1'b1; tick(); clear = 1'b0;
    check("clr_retired", retired, 0);
    for (int i = 0; i < 10; i++) begin
      set_rec(32'h100 + 32'(4*i)); update = 1'b1; tick();
    end
    update = 1'b0;
    check("ovf_fill", fill, 8);
    check("ovf_dropped", dropped, 2);
    check("ovf_flag", overflow, 1);
    check("ovf_retired", retired, 10);
    check("ovf_head", obs_fields(), exp_fields(32'h100));

    // Full with simultaneous push and pop
    set_rec(32'h200); update = 1'b1; ready = 1'b1; tick();
    update = 1'b0;
    check("fpp_fill", fill, 8);
    check("fpp_dropped", dropped, 2);
    check("fpp_retired", retired, 11);
    // Drain: records 2..8 of the overflow burst, then the wrapped tail
    for (int i = 0; i < 8; i++) begin
      logic [31:0] e;
      e = (i < 7) ? 32'h104 + 32'(4*i) : 32'h200;
      check($sformatf("drain_head%0d", i), obs_fields(), exp_fields(e));
      tick();
    end
    check("drain_fill", fill, 0);
    check("drain_valid", valid, 0);

    // Clear together with update (no drop)
    ready = 1'b0; clear = 1'b1; update = 1'b1; set_rec(32'h300); tick();
    clear = 1'b0; update = 1'b0;
    check("clru_retired", retired, 1);
    check("clru_dropped", dropped, 0);
    check("clru_overflow", overflow, 0);
    check("clru_fill", fill, 1);

    // Clear together with a drop
    for (int i = 1; i < 8; i++) begin
      set_rec(32'h300 + 32'(4*i)); update = 1'b1; tick();
    end
    check("clrd_prefill", fill, 8);
    clear = 1'b1; set_rec(32'h400); update = 1'b1; tick();
    clear = 1'b0; update = 1'b0;
    check("clrd_retired", retired, 1);
    check("clrd_dropped", dropped, 1);
    check("clrd_overflow", overflow, 1);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("clrd_drain", fill, 0);

    // Backpressure run against a queue model
    sent = 0; stall = 1'b0; prev = '0; cyc = 0;
    while ((sent < 100 || q.size() != 0) && cyc < 3000) begin
      cyc++;
      rdy = 1'($urandom_range(0, 1));
      upd = (sent < 100) && ($urandom_range(0, 3) != 0);
      pop = (q.size() != 0) && rdy;
      if (upd && q.size() == DEPTH && !pop) upd = 1'b0;
      check("bp_valid", valid, (q.size() != 0));
      if (stall) check("bp_stable", obs_fields(), prev);
      if (pop) check("bp_data", obs_fields(), exp_fields(q[0]));
      stall = valid && !rdy;
      prev  = obs_fields();
      ready = rdy; update = upd; set_rec(32'h1000 + 32'(4*sent));
      tick();
      if (pop) void'(q.pop_front());
      if (upd) begin
        q.push_back(32'h1000 + 32'(4*sent));
        sent++;
      end
      check("bp_fill", fill, q.size());
    end
    update = 1'b0; ready = 1'b0;
    check("bp_done", {sent, q.size()}, {32'd100, 32'd0});
    check("bp_dropped", dropped, 1);

    // Retired counter wrap
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_overflow", overflow, 0);
    force dut.retired_cnt_o = 32'hFFFF_FFFF;
    #1 release dut.retired_cnt_o;
    set_rec(32'h500); update = 1'b1; tick(); update = 1'b0;
    check("wrap_retired", retired, 32'h0);
    check("wrap_fill", fill, 1);

    // Dropped counter saturation
    for (int i = 1; i < 8; i++) begin
      set_rec(32'h500 + 32'(4*i)); update = 1'b1; tick();
    end
    update = 1'b0;
    force dut.dropped_cnt_o = 32'hFFFF_FFFF;
    #1 release dut.dropped_cnt_o;
    set_rec(32'h600); update = 1'b1; tick(); update = 1'b0;
    check("sat_dropped", dropped, 32'hFFFF_FFFF);
    check("sat_overflow", overflow, 1);
    check("sat_fill", fill, 8);
    check("sat_head", obs_fields(), exp_fields(32'h500));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/retire_trace_buffer.md
# retire_trace_buffer

Receives the per-instruction retire record emitted by the single-cycle core (`update`, `pc`, `instr`, register write-back, memory access) and queues it in a FIFO. A downstream logger, scoreboard or debug port drains the queue over a valid/ready stream. The block also keeps a retired-instruction counter, a dropped-record counter and a sticky overflow flag, so a slow consumer never stalls the core and a lost record is always visible.

## Interface
- `XLEN`, 32: data/address width of every record field.
- `DEPTH`, 8: FIFO entries; a power of two, ≥ 2.
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_i` in 1: reset, asynchronous and active-high.
- `update_i` in 1: a record is present this cycle (one instruction retired).
- `pc_i` in XLEN: retired PC.
- `instr_i` in XLEN: retired instruction word.
- `reg_addr_i` in 5: destination register (0 = no write-back).
- `reg_data_i` in XLEN: write-back data.
- `mem_addr_i` in XLEN: memory access address.
- `mem_data_i` in XLEN: memory write data.
- `mem_wrt_i` in 1: the record is a store.
- `trace_valid_o` out 1: head record is available.
- `trace_ready_i` in 1: consumer accepts the head record.
- `trace_pc_o`, `trace_instr_o`, `trace_reg_data_o`, `trace_mem_addr_o`, `trace_mem_data_o` out XLEN each; `trace_reg_addr_o` out 5; `trace_mem_wrt_o` out 1: head record fields.
- `fill_o` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `retired_cnt_o` out 32: count of `update_i` pulses, including dropped records; wraps 0xFFFFFFFF→0.
- `dropped_cnt_o` out 32: count of records lost to a full FIFO; saturates at 0xFFFFFFFF.
- `overflow_o` out 1: sticky; set on the first drop.
- `clear_i` in 1: synchronous clear of both counters and `overflow_o`. FIFO contents are untouched.

## Operation
- **Storage:** circular buffer of DEPTH records, with write pointer, read pointer and an occupancy counter. Pointers wrap DEPTH-1→0.
- **Push:** `update_i`=1 and (fill < DEPTH, or a pop in the same cycle). The record is written at the write pointer, and the pointer advances.
- **Pop:** `trace_valid_o`=1 and `trace_ready_i`=1. The read pointer advances.
- **Simultaneous push and pop:** fill is unchanged.
  - When full, the push is accepted because the pop frees a slot.
  - When empty, there is no pop (`trace_valid_o`=0). The push goes in and fill becomes 1.
- **Drop:** `update_i`=1, fill = DEPTH and no pop. The record is discarded, `dropped_cnt_o` increments (saturating) and `overflow_o` sets.
- **`trace_valid_o`** = (fill ≠ 0).
- **Output fields:**
  - Driven by the entry at the read pointer.
  - Stable while `trace_valid_o`=1 and `trace_ready_i`=0.
  - Don't-care while `trace_valid_o`=0.
- **Ordering:** records leave in strict retirement order. No reordering, no filtering; `reg_addr_i`=0 records are queued normally.
- **`clear_i`:** takes priority over the counter updates in the same cycle.
  - `retired_cnt_o` becomes `update_i` ? 1 : 0.
  - `dropped_cnt_o` becomes 1 and `overflow_o` becomes 1 if a drop occurs in that same cycle; otherwise both become 0.
- **`trace_ready_i` without valid** has no effect.

## Timing
- **Reset values** (asynchronous, immediate): pointers 0; `fill_o` 0; `trace_valid_o` 0; `retired_cnt_o` 0; `dropped_cnt_o` 0; `overflow_o` 0. FIFO storage is not reset.
- **Reset mid-operation:** all queued records are discarded. The first `update_i` after deassertion is entry 0.
- **Latency:** a record pushed at edge N is on the `trace_*` outputs, with `trace_valid_o`=1, after edge N. There is no same-cycle bypass.
- **Throughput:** one push and one pop per cycle, sustained indefinitely.
- **Counter and flag timing:** all counters and `fill_o` are registered and reflect the events of edge N after edge N.
- **Inputs are sampled only at the clock edge.** `update_i` is a one-cycle qualifier; the record fields are ignored when it is 0.

## Test plan
- **Reset then 3 pushes, no pop:**
  - After the 3rd edge: `fill_o`=3, `trace_valid_o`=1, `trace_pc_o` = first PC (e.g. 0x00000000), `retired_cnt_o`=3.
  - Assert `rst_i` mid-cycle: `fill_o` and `trace_valid_o` drop to 0 immediately.
- **Ordering:** push PCs 0x0, 0x4, …, 0x1C (DEPTH=8) with `trace_ready_i`=1 throughout.
  - Outputs appear one cycle later in the same order.
  - `fill_o` never exceeds 1; `dropped_cnt_o`=0.
- **Overflow:** `trace_ready_i`=0 and 10 pushes.
  - Result: `fill_o`=8, `dropped_cnt_o`=2, `overflow_o`=1, `retired_cnt_o`=10.
  - The head is the 1st record and the tail is the 8th.
- **Full with simultaneous push and pop:** FIFO full, then `update_i`=1 and `trace_ready_i`=1 for one cycle.
  - Result: `fill_o` stays 8, no drop, and the new record lands at the tail after wrap-around.
- **Backpressure stability:** toggle `trace_ready_i` pseudo-randomly for 100 records.
  - Every output field stays stable while valid && !ready.
  - The consumer scoreboard matches the pushed sequence exactly.
- **Clear and counter edges:**
  - `clear_i` together with `update_i`: `retired_cnt_o`=1, `dropped_cnt_o`=0, `overflow_o`=0.
  - Preload `retired_cnt_o`=0xFFFFFFFF via pushes or force, then push: it wraps to 0.
